// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared widths, typedefs and operand struct for the rename register file
package rename_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);
    localparam int TAG_W  = 4;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [TAG_W-1:0]  rob_tag_t;
    typedef logic [XLEN-1:0]   xdata_t;

    typedef struct packed {
        xdata_t   val;
        logic     busy;
        rob_tag_t tag;
    } operand_t;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one operand read port with commit-to-read bypass
module rf_read_port
    import rename_pkg::*;
#(
    parameter int NCMT = 2
) (
    input  reg_addr_t               addr,
    input  xdata_t                  reg_val,
    input  logic                    reg_busy,
    input  rob_tag_t                reg_tag,
    input  logic [NCMT-1:0]         cmt_sig,
    input  logic [NCMT*REG_AW-1:0]  cmt_rd,
    input  logic [NCMT*XLEN-1:0]    cmt_val,
    input  logic [NCMT*TAG_W-1:0]   cmt_tag,
    output operand_t                operand
);
    always_comb begin
        operand.val  = reg_val;
        operand.busy = reg_busy;
        operand.tag  = reg_tag;
        if (addr == '0) begin
            operand = '0;
        end else begin
            // Ascending scan: the youngest matching commit port wins.
            for (int k = 0; k < NCMT; k++) begin
                if (cmt_sig[k] && cmt_rd[k*REG_AW +: REG_AW] == addr && reg_busy &&
                    cmt_tag[k*TAG_W +: TAG_W] == reg_tag) begin
                    operand.val  = cmt_val[k*XLEN +: XLEN];
                    operand.busy = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/rename_reg_file.sv
// rtl/rename_reg_file.sv - architectural register file with ROB rename tags and busy count
module rename_reg_file
    import rename_pkg::*;
#(
    parameter int NRD  = 4,
    parameter int NCMT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    issue_sig,
    input  reg_addr_t               issue_rd,
    input  rob_tag_t                issue_tag,
    input  logic [NRD*REG_AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0]     rd_val,
    output logic [NRD-1:0]          rd_busy,
    output logic [NRD*TAG_W-1:0]    rd_tag,
    input  logic [NCMT-1:0]         cmt_sig,
    input  logic [NCMT*REG_AW-1:0]  cmt_rd,
    input  logic [NCMT*XLEN-1:0]    cmt_val,
    input  logic [NCMT*TAG_W-1:0]   cmt_tag,
    input  logic                    flush,
    output logic [REG_AW:0]         busy_cnt
);
    xdata_t          reg_val [NREG];
    rob_tag_t        tag     [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] busy_nxt;
    logic [REG_AW:0] n_clr;
    logic [REG_AW:0] cnt_nxt;
    logic            set_new;
    logic            dup_tag;

    always_comb begin
        clr = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int k = 0; k < NCMT; k++) begin
                if (cmt_sig[k] && cmt_rd[k*REG_AW +: REG_AW] == REG_AW'(r) && busy[r] &&
                    tag[r] == cmt_tag[k*TAG_W +: TAG_W] &&
                    !(issue_sig && issue_rd == REG_AW'(r))) begin
                    clr[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        set_new = issue_sig && !flush && issue_rd != '0;
        n_clr   = '0;
        for (int r = 0; r < NREG; r++) begin
            n_clr = n_clr + (REG_AW+1)'(clr[r]);
        end
        busy_nxt = busy & ~clr;
        if (set_new) busy_nxt[issue_rd] = 1'b1;
        if (flush) begin
            busy_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            // Re-issue to an already busy register leaves the count alone.
            cnt_nxt = busy_cnt + (REG_AW+1)'(set_new && !busy[issue_rd]) - n_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                reg_val[i] <= '0;
                tag[i]     <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else if (rdy) begin
            for (int k = 0; k < NCMT; k++) begin
                if (cmt_sig[k] && cmt_rd[k*REG_AW +: REG_AW] != '0)
                    reg_val[cmt_rd[k*REG_AW +: REG_AW]] <= cmt_val[k*XLEN +: XLEN];
            end
            if (set_new) tag[issue_rd] <= issue_tag;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        reg_addr_t ra;
        operand_t  op;
        assign ra = rd_addr[p*REG_AW +: REG_AW];
        rf_read_port #(.NCMT(NCMT)) u_rp (
            .addr     (ra),
            .reg_val  (reg_val[ra]),
            .reg_busy (busy[ra]),
            .reg_tag  (tag[ra]),
            .cmt_sig  (cmt_sig),
            .cmt_rd   (cmt_rd),
            .cmt_val  (cmt_val),
            .cmt_tag  (cmt_tag),
            .operand  (op)
        );
        assign rd_val[p*XLEN +: XLEN]   = op.val;
        assign rd_busy[p]               = op.busy;
        assign rd_tag[p*TAG_W +: TAG_W] = op.tag;
    end

    always_comb begin
        dup_tag = 1'b0;
        for (int a = 0; a < NCMT; a++)
            for (int b = a + 1; b < NCMT; b++)
                if (cmt_sig[a] && cmt_sig[b] &&
                    cmt_tag[a*TAG_W +: TAG_W] == cmt_tag[b*TAG_W +: TAG_W])
                    dup_tag = 1'b1;
    end

    a_no_dup_tag: assert property (@(posedge clk) disable iff (!rst_n) rdy |-> !dup_tag);
endmodule

// File: tb/tb_rename_reg_file.sv
// tb/tb_rename_reg_file.sv - directed self-checking bench for rename_reg_file
module tb_rename_reg_file;
    import rename_pkg::*;
    localparam int NRD  = 4;
    localparam int NCMT = 2;

    logic                   clk = 1'b0;
    logic                   rst_n, rdy, issue_sig, flush;
    reg_addr_t              issue_rd;
    rob_tag_t               issue_tag;
    logic [NRD*REG_AW-1:0]  rd_addr;
    logic [NRD*XLEN-1:0]    rd_val;
    logic [NRD-1:0]         rd_busy;
    logic [NRD*TAG_W-1:0]   rd_tag;
    logic [NCMT-1:0]        cmt_sig;
    logic [NCMT*REG_AW-1:0] cmt_rd;
    logic [NCMT*XLEN-1:0]   cmt_val;
    logic [NCMT*TAG_W-1:0]  cmt_tag;
    logic [REG_AW:0]        busy_cnt;

    int checks = 0;
    int failures = 0;

    rename_reg_file #(.NRD(NRD), .NCMT(NCMT)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .issue_sig(issue_sig), .issue_rd(issue_rd),
        .issue_tag(issue_tag), .rd_addr(rd_addr), .rd_val(rd_val), .rd_busy(rd_busy),
        .rd_tag(rd_tag), .cmt_sig(cmt_sig), .cmt_rd(cmt_rd), .cmt_val(cmt_val),
        .cmt_tag(cmt_tag), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        issue_sig = 1'b0;
        cmt_sig   = '0;
        flush     = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*REG_AW +: REG_AW] = REG_AW'(a);
    endtask

    task automatic do_issue(input int r, input int t);
        issue_sig = 1'b1;
        issue_rd  = REG_AW'(r);
        issue_tag = TAG_W'(t);
    endtask

    task automatic do_cmt(input int k, input int r, input int t, input logic [31:0] v);
        cmt_sig[k] = 1'b1;
        cmt_rd[k*REG_AW +: REG_AW] = REG_AW'(r);
        cmt_tag[k*TAG_W +: TAG_W]  = TAG_W'(t);
        cmt_val[k*XLEN +: XLEN]    = v;
    endtask

    task automatic chk_rd(input string name, input int p, input logic [31:0] v, input logic b);
        chk({name, ".val"}, 64'(rd_val[p*XLEN +: XLEN]), 64'(v));
        chk({name, ".busy"}, 64'(rd_busy[p]), 64'(b));
    endtask

    task automatic chk_tag(input string name, input int p, input int t);
        chk({name, ".tag"}, 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; issue_sig = 1'b0; flush = 1'b0;
        issue_rd = '0; issue_tag = '0; cmt_sig = '0; cmt_rd = '0; cmt_val = '0; cmt_tag = '0;
        for (int p = 0; p < NRD; p++) set_rd(p, 5);
        #12;
        for (int p = 0; p < NRD; p++) chk_rd("rst_x5", p, 32'h0, 1'b0);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Issue then commit with same-cycle bypass
        do_issue(3, 7); tick();
        set_rd(1, 3); #1;
        chk_rd("iss_x3", 1, 32'h0, 1'b1);
        chk_tag("iss_x3", 1, 7);
        chk("iss_cnt", 64'(busy_cnt), 64'd1);
        do_cmt(0, 3, 7, 32'hDEAD); #1;
        chk_rd("byp_x3", 1, 32'hDEAD, 1'b0);
        tick(); #1;
        chk_rd("cmt_x3", 1, 32'hDEAD, 1'b0);
        chk("cmt_cnt", 64'(busy_cnt), 64'd0);

        // Stale-tag commit writes value but keeps newer rename
        do_issue(3, 7); tick();
        do_issue(3, 9); tick();
        chk("reiss_cnt", 64'(busy_cnt), 64'd1);
        do_cmt(0, 3, 7, 32'h11); #1;
        chk_rd("stale_byp", 1, 32'hDEAD, 1'b1);
        tick(); #1;
        chk_rd("stale_x3", 1, 32'h11, 1'b1);
        chk_tag("stale_x3", 1, 9);
        chk("stale_cnt", 64'(busy_cnt), 64'd1);

        // Same-cycle commit and issue on x4
        do_issue(4, 2); tick();
        chk("x4_cnt0", 64'(busy_cnt), 64'd2);
        do_issue(4, 5); do_cmt(0, 4, 2, 32'h44); tick();
        set_rd(2, 4); #1;
        chk_rd("x4_pri", 2, 32'h44, 1'b1);
        chk_tag("x4_pri", 2, 5);
        chk("x4_cnt", 64'(busy_cnt), 64'd2);

        // Dual commit on x6, port1 holds the live tag
        do_issue(6, 1); tick();
        do_issue(6, 2); tick();
        chk("x6_cnt0", 64'(busy_cnt), 64'd3);
        set_rd(3, 6);
        do_cmt(0, 6, 1, 32'hA); do_cmt(1, 6, 2, 32'hB); #1;
        chk_rd("dual_byp", 3, 32'hB, 1'b0);
        tick(); #1;
        chk_rd("dual_x6", 3, 32'hB, 1'b0);
        chk("dual_cnt", 64'(busy_cnt), 64'd2);

        // Stall holds all state
        rdy = 1'b0;
        do_issue(9, 3); do_cmt(0, 3, 9, 32'h77); tick();
        rdy = 1'b1;
        set_rd(0, 9); #1;
        chk_rd("stall_x9", 0, 32'h0, 1'b0);
        chk_rd("stall_x3", 1, 32'h11, 1'b1);
        chk("stall_cnt", 64'(busy_cnt), 64'd2);

        // Flush with same-cycle commit and issue
        do_issue(1, 1); tick();
        do_issue(2, 2); tick();
        do_issue(7, 3); tick();
        chk("pre_flush_cnt", 64'(busy_cnt), 64'd5);
        flush = 1'b1; do_cmt(0, 1, 1, 32'h55); do_issue(8, 4); tick();
        set_rd(0, 1); set_rd(1, 2); set_rd(2, 7); set_rd(3, 8); #1;
        chk_rd("fl_x1", 0, 32'h55, 1'b0);
        chk_rd("fl_x2", 1, 32'h0, 1'b0);
        chk_rd("fl_x7", 2, 32'h0, 1'b0);
        chk_rd("fl_x8", 3, 32'h0, 1'b0);
        chk("fl_cnt", 64'(busy_cnt), 64'd0);

        // x0 ignores issue and commit
        do_issue(0, 5); do_cmt(0, 0, 5, 32'h99); tick();
        set_rd(0, 0); #1;
        chk_rd("x0", 0, 32'h0, 1'b0);
        chk("x0_cnt", 64'(busy_cnt), 64'd0);

        // Asynchronous reset clears outputs without a clock edge
        do_issue(5, 6); tick();
        do_cmt(0, 5, 6, 32'h66); tick();
        do_issue(5, 7); tick();
        set_rd(0, 5); #1;
        chk_rd("pre_arst", 0, 32'h66, 1'b1);
        chk("pre_arst_cnt", 64'(busy_cnt), 64'd1);
        rst_n = 1'b0; #1;
        chk_rd("arst", 0, 32'h0, 1'b0);
        chk("arst_cnt", 64'(busy_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register ROB rename tags for the out-of-order core.
- Successor to the single-issue, single-commit register file. Adds a parametrised number of read ports and commit ports, correct flush semantics, commit-to-read bypass on every port, and a registered count of busy registers.
- Sits between the dispatcher (issue and operand read) and the ROB (commit and flush).

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- TAG_W, 4, ROB tag width.
- NRD, 4, number of read ports (two per issued instruction).
- NCMT, 2, number of commit ports; a higher port index means a younger instruction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global stall; when low, all state holds.
- issue_sig  in  1  rename the destination of the issuing instruction.
- issue_rd  in  log2(NREG)  destination register.
- issue_tag  in  TAG_W  ROB tag assigned to issue_rd.
- rd_addr  in  NRD*log2(NREG)  read addresses, flattened.
- rd_val  out  NRD*XLEN  read values.
- rd_busy  out  NRD  1 = operand not ready; wait on rd_tag.
- rd_tag  out  NRD*TAG_W  producing ROB tag, valid when rd_busy=1.
- cmt_sig  in  NCMT  per-port commit valid.
- cmt_rd  in  NCMT*log2(NREG)  commit destinations.
- cmt_val  in  NCMT*XLEN  commit values.
- cmt_tag  in  NCMT*TAG_W  commit ROB tags.
- flush  in  1  mispredict recovery; drop all rename tags.
- busy_cnt  out  log2(NREG)+1  registered number of registers with busy=1.

Behaviour:
- Reset (asynchronous, rst_n=0): every reg_val=0, busy=0, tag=0, busy_cnt=0.
- Read outputs are combinational and valid regardless of reset; during reset they read as val=0, busy=0.
- All updates occur on the rising clk edge when rst_n=1 and rdy=1. With rdy=0, no state changes.
- x0: reads always return val=0 and busy=0. Issue and commit to x0 are ignored.
- Value write: for each port k with cmt_sig[k]=1, reg_val[cmt_rd[k]] <= cmt_val[k].
  - If two ports target the same register, the higher k wins.
  - The value write happens even if the tag no longer matches (a newer in-flight writer exists).
- Tag clear: for port k, clear busy[r] only if all of the following hold:
  - busy[r]=1 and tag[r]==cmt_tag[k];
  - not (issue_sig and issue_rd==r).
- Issue: issue_sig with issue_rd!=0 sets busy[issue_rd]<=1 and tag[issue_rd]<=issue_tag. Issue has priority over a same-cycle tag clear.
- Flush: all busy<=0 and busy_cnt<=0. Same-cycle commits still write values. Same-cycle issue is ignored.
- Read bypass, per read port p with r=rd_addr[p]:
  - If some commit port k has cmt_sig[k], cmt_rd[k]==r!=0, busy[r]=1 and cmt_tag[k]==tag[r], return val=cmt_val[k] and busy=0. The highest matching k wins.
  - Otherwise return {reg_val[r], busy[r], tag[r]}.
- Reads never see a same-cycle issue. The dispatcher forwards intra-bundle dependencies itself.
- busy_cnt equals the popcount of busy after each edge. Computed incrementally:
  - +1 if issue sets a previously clear busy bit;
  - −1 per distinct register cleared;
  - a re-issue to a busy register adds 0.
- busy_cnt never exceeds NREG−1 (x0 is never busy).
- The ROB never commits the same tag on two ports. This is a checked assertion, not handled in RTL.
- Latency: issue and commit are visible to reads in the next cycle. The commit bypass has zero-cycle latency.

Decomposition:
- Package rename_pkg holds:
  - constants XLEN, NREG, REG_AW=log2(NREG), TAG_W;
  - typedefs reg_addr_t, rob_tag_t, xdata_t;
  - struct operand_t {val, busy, tag}, shared with the dispatcher and RS.
- One sub-module, rf_read_port: a combinational bypass mux, instantiated NRD times via generate. State and the busy_cnt logic stay in the top module.

Test Plan:
- Reset then read x5 on all ports: val=0, busy=0, busy_cnt=0. Assert rst_n=0 mid-run with busy regs: outputs clear immediately, without waiting for clk.
- Issue x3 tag 7; next cycle read x3 → busy=1, tag=7, busy_cnt=1. Commit x3 tag 7 val 0xDEAD: the same-cycle read returns 0xDEAD with busy=0; the next cycle gives reg_val=0xDEAD, busy_cnt=0.
- Issue x3 tag 7, then issue x3 tag 9, then commit tag 7 val 0x11: x3 stays busy with tag 9, reg_val=0x11, and a read bypass does not fire.
- Same cycle: commit x4 tag 2 and issue x4 tag 5 → busy=1, tag=5, reg_val updated, busy_cnt unchanged.
- Dual commit: port0 commits x6 tag 1 val 0xA, port1 commits x6 tag 2 val 0xB, with tag[x6]=2 → read bypass returns 0xB, final reg_val=0xB, busy cleared.
- Busy x1, x2 and x7, then flush together with commit x1 val 0x55 and issue x8 → all busy=0, busy_cnt=0, reg_val[x1]=0x55, x8 not busy. With rdy=0 during issue, there is no change.
